// File: rtl/ds_result_writer.sv
// Result write-back stage: accepts averaged kernel results and writes them as raster-ordered pixels.
// Optional SAT_CLAMP_EN: saturate oversized results to all ones and count them on sat_cnt.
module ds_result_writer #(
    parameter int OUT_W  = 4,
    parameter int OUT_H  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              done
`ifdef SAT_CLAMP_EN
    ,
    output logic [ADDR_W:0]   sat_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for start, inputs ignored
    // ACCEPT | res_ready high, waiting for a result handshake
    // WRITE  | one-cycle memory write of the latched pixel
    // DONE   | one-cycle done pulse, raster position cleared
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              col_end, last_pix, hs;
    logic [ADDR_W-1:0] addr_cur;
    logic [PIX_W-1:0]  pix;
    logic              ovf;

    assign col_end  = (col == CW'(OUT_W - 1));
    assign last_pix = col_end && (row == RW'(OUT_H - 1));
    assign addr_cur = ADDR_W'(32'(row) * OUT_W + 32'(col));
    assign hs       = res_valid && res_ready;
    assign ovf      = |res_data[DATA_W-1:PIX_W];

`ifdef SAT_CLAMP_EN
    assign pix = ovf ? {PIX_W{1'b1}} : res_data[PIX_W-1:0];
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign pix = res_data[PIX_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        res_ready = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                res_ready = 1'b1;
                busy      = 1'b1;
                if (res_valid) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                state_nxt = last_pix ? DONE : ACCEPT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and data are captured at the handshake so they hold steady between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (hs) begin
                mem_addr  <= addr_cur;
                mem_wdata <= pix;
            end
            if (state == WRITE && !last_pix) begin
                if (col_end) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == DONE) begin
                col <= '0;
                row <= '0;
            end
        end
    end

`ifdef SAT_CLAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     sat_cnt <= '0;
        else if (state == IDLE && start) sat_cnt <= '0;
        else if (hs && ovf)             sat_cnt <= sat_cnt + 1'b1;
    end
`endif

endmodule
